// File: rtl/mac_acc_sequencer_pkg.sv
// Shared constants and types for the MAC accumulate-job sequencer.
// Holds the cfg field positions, mode codes and the sequencer state encoding.
package mac_acc_sequencer_pkg;

  // cfg field positions
  localparam int MAC_CFG_SIGNED_BIT = 3;
  localparam int MAC_CFG_MODE_LSB   = 0;

  // mode codes carried in cfg[1:0]
  localparam logic [1:0] MAC_MODE_SINGLE = 2'b00;
  localparam logic [1:0] MAC_MODE_DUAL   = 2'b01;
  localparam logic [1:0] MAC_MODE_QUAD   = 2'b10;
  localparam logic [1:0] MAC_MODE_RSVD   = 2'b11;

  // sequencer state encoding
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  // True when the mode code is one the datapath actually implements.
  function automatic logic mac_mode_known(input logic [1:0] mode);
    return (mode == MAC_MODE_SINGLE) || (mode == MAC_MODE_DUAL) ||
           (mode == MAC_MODE_QUAD);
  endfunction

endpackage

// File: rtl/mac_seq_down_counter.sv
// Loadable down-counter with zero and one flags.
// Load has priority over decrement; decrement saturates at zero.
module mac_seq_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins, otherwise decrement while non-zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {WIDTH{1'b0}})) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {WIDTH{1'b0}});
  assign last_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/mac_acc_sequencer.sv
// Sequencer in front of the MAC multiply/accumulate/negate datapath.
// Accepts one job command, gates PIPE_DEPTH-aware operand flow, then
// captures the four accumulator lanes and returns them on a valid/ready port.
// Optional build macro: MAC_SEQ_CFG_CHECK_EN -- reject reserved mode 2'b11
// with an error result instead of passing it to the datapath.
module mac_acc_sequencer
  import mac_acc_sequencer_pkg::*;
#(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_ACC_WIDTH  = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int PIPE_DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [MAC_CONF_WIDTH-1:0]  cmd_cfg,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic                       op_valid,
  output logic                       op_ready,
  output logic [MAC_CONF_WIDTH-1:0]  mac_cfg,
  output logic                       mac_en,
  output logic                       mac_acc_clr,
  input  logic [4*MAC_ACC_WIDTH-1:0] mac_acc_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [4*MAC_ACC_WIDTH-1:0] res_data,
  output logic                       res_err,
  output logic                       busy
);

  localparam int DRAIN_W = (PIPE_DEPTH < 2) ? 1 : $clog2(PIPE_DEPTH + 1);

  seq_state_e state_q;
  seq_state_e state_d;

  logic [MAC_CONF_WIDTH-1:0]  mac_cfg_q;
  logic [4*MAC_ACC_WIDTH-1:0] res_data_q;
  logic                       res_err_q;
  logic                       first_q;

  logic cmd_rsvd_s;
  logic cmd_take_s;
  logic cmd_ready_s;
  logic op_ready_s;
  logic mac_en_s;
  logic busy_s;
  logic res_valid_s;
  logic beat_zero_s;
  logic beat_last_s;
  logic drain_zero_s;
  logic drain_last_s;
  logic drain_load_s;
  logic drain_dec_s;
  logic capture_s;

`ifdef MAC_SEQ_CFG_CHECK_EN
  assign cmd_rsvd_s = !mac_mode_known(cmd_cfg[MAC_CFG_MODE_LSB +: 2]);
`else
  assign cmd_rsvd_s = 1'b0;
`endif

  // Remaining-beat counter: loaded with cmd_len, one step per accepted beat.
  mac_seq_down_counter #(.WIDTH(LEN_WIDTH)) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cmd_take_s),
    .load_val_i (cmd_len),
    .dec_i      (mac_en_s),
    .zero_o     (beat_zero_s),
    .last_o     (beat_last_s)
  );

  // Drain counter: covers the datapath latency after the final beat.
  mac_seq_down_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (drain_load_s),
    .load_val_i (DRAIN_W'(PIPE_DEPTH)),
    .dec_i      (drain_dec_s),
    .zero_o     (drain_zero_s),
    .last_o     (drain_last_s)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: begin
        if (cmd_valid) begin
          if ((cmd_len == {LEN_WIDTH{1'b0}}) || cmd_rsvd_s) begin
            state_d = SEQ_DONE;
          end else begin
            state_d = SEQ_RUN;
          end
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_RUN: begin
        if (mac_en_s && beat_last_s) begin
          state_d = SEQ_DRAIN;
        end else begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_DRAIN: begin
        // The zero guard only matters if the counter was never loaded.
        if (drain_last_s || drain_zero_s) begin
          state_d = SEQ_DONE;
        end else begin
          state_d = SEQ_DRAIN;
        end
      end
      SEQ_DONE: begin
        if (res_ready) begin
          state_d = SEQ_IDLE;
        end else begin
          state_d = SEQ_DONE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Output and counter-control decode from the current state.
  always_comb begin
    cmd_ready_s = 1'b0;
    op_ready_s  = 1'b0;
    busy_s      = 1'b1;
    res_valid_s = 1'b0;
    drain_dec_s = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        cmd_ready_s = 1'b1;
        busy_s      = 1'b0;
      end
      SEQ_RUN:   op_ready_s  = !beat_zero_s;
      SEQ_DRAIN: drain_dec_s = 1'b1;
      SEQ_DONE:  res_valid_s = 1'b1;
      default: begin
        cmd_ready_s = 1'b0;
        busy_s      = 1'b1;
      end
    endcase
    cmd_take_s   = cmd_ready_s & cmd_valid;
    mac_en_s     = op_valid & op_ready_s;
    drain_load_s = mac_en_s & beat_last_s;
    capture_s    = drain_dec_s & (drain_last_s | drain_zero_s);
  end

  // Job configuration, first-beat flag and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mac_cfg_q  <= {MAC_CONF_WIDTH{1'b0}};
      res_data_q <= {(4*MAC_ACC_WIDTH){1'b0}};
      res_err_q  <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      if (cmd_take_s) begin
        // A rejected command leaves the datapath cfg untouched.
        if (!cmd_rsvd_s) begin
          mac_cfg_q <= cmd_cfg;
        end
        res_data_q <= {(4*MAC_ACC_WIDTH){1'b0}};
        res_err_q  <= cmd_rsvd_s;
        first_q    <= 1'b1;
      end else begin
        if (mac_en_s) begin
          first_q <= 1'b0;
        end
        if (capture_s) begin
          res_data_q <= mac_acc_in;
        end
      end
    end
  end

  assign cmd_ready   = cmd_ready_s;
  assign op_ready    = op_ready_s;
  assign mac_en      = mac_en_s;
  assign mac_acc_clr = mac_en_s & first_q;
  assign busy        = busy_s;
  assign res_valid   = res_valid_s;
  assign mac_cfg     = mac_cfg_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_mac_acc_sequencer.sv
// Self-checking bench for mac_acc_sequencer: table of directed jobs,
// hand-written reset-mid-job sequence, and randomized jobs checked against
// a timeline model (beat count, last-accept cycle, capture cycle).
module tb_mac_acc_sequencer;

  localparam int P = 2;
  localparam logic [127:0] PAT = 128'h44444444_33333333_22222222_11111111;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_cfg;
  logic [7:0]   cmd_len;
  logic         op_valid;
  logic         op_ready;
  logic [3:0]   mac_cfg;
  logic         mac_en;
  logic         mac_acc_clr;
  logic [127:0] mac_acc_in;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         res_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] last_cfg;

  mac_acc_sequencer #(
    .MAC_CONF_WIDTH (4),
    .MAC_ACC_WIDTH  (32),
    .LEN_WIDTH      (8),
    .PIPE_DEPTH     (P)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_cfg     (cmd_cfg),
    .cmd_len     (cmd_len),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .mac_cfg     (mac_cfg),
    .mac_en      (mac_en),
    .mac_acc_clr (mac_acc_clr),
    .mac_acc_in  (mac_acc_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  cfg;
    logic [7:0]  len;
    int          vprob;     // percent op_valid; 0 selects ov_pat
    logic [15:0] ov_pat;    // op_valid per cycle after the command, LSB first
    int          rdelay;    // cycles res_ready stays low once result is valid
    bit          use_pat;   // drive fixed lane pattern on mac_acc_in
    int          exp_beats; // mac_en pulses expected for the job
  } vec_t;

  // Runs one job from IDLE; entered and left at posedge+1.
  task automatic do_job(input logic [3:0] cfg, input logic [7:0] len, input int vprob,
                        input logic [15:0] ov_pat, input int rdelay, input bit use_pat,
                        output int beats);
    logic [127:0] acc_v;
    logic [127:0] exp_data;
    logic [3:0]   exp_cfg;
    bit rsvd, ov, fin, exp_rdy, exp_en, in_done;
    int last_t, done_t, wait_n;
`ifdef MAC_SEQ_CFG_CHECK_EN
    rsvd = (cfg[1:0] == 2'b11);
`else
    rsvd = 1'b0;
`endif
    cmd_valid = 1'b1; cmd_cfg = cfg; cmd_len = len;
    op_valid = 1'($urandom_range(1)); res_ready = 1'b0;
    #3;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
    chk("op_ready_idle", op_ready, 1'b0);
    @(posedge clk); #1;
    if (!rsvd) last_cfg = cfg;
    exp_cfg = last_cfg;
    beats = 0; last_t = -1; wait_n = 0; fin = 1'b0;
    exp_data = '0;
    done_t = ((len == 8'd0) || rsvd) ? 1 : -1;
    for (int t = 1; t < 4000 && !fin; t++) begin
      if (vprob == 0) ov = (t <= 16) ? ov_pat[t-1] : 1'b1;
      else            ov = ($urandom_range(99) < vprob);
      acc_v = use_pat ? PAT : {$urandom, $urandom, $urandom, $urandom};
      in_done = (done_t > 0) && (t >= done_t);
      op_valid = ov; mac_acc_in = acc_v;
      cmd_valid = 1'b1; cmd_len = 8'($urandom); cmd_cfg = 4'($urandom);
      res_ready = in_done && (wait_n >= rdelay);
      #3;
      exp_rdy = (done_t < 0) && (beats < int'(len));
      exp_en  = exp_rdy && ov;
      chk("op_ready", op_ready, exp_rdy);
      chk("mac_en", mac_en, exp_en);
      chk("mac_acc_clr", mac_acc_clr, exp_en && (beats == 0));
      chk("cmd_ready_busy", cmd_ready, 1'b0);
      chk("busy", busy, 1'b1);
      chk("mac_cfg", mac_cfg, exp_cfg);
      chk("res_valid", res_valid, in_done);
      if (in_done) begin
        chk("res_data", res_data, exp_data);
        chk("res_err", res_err, rsvd);
      end
      if (exp_en) begin
        beats++;
        if (beats == int'(len)) begin
          last_t = t;
          done_t = t + P + 1;
        end
      end
      if ((last_t >= 0) && (t == last_t + P)) exp_data = acc_v;
      if (in_done) begin
        if (res_ready) fin = 1'b1;
        else wait_n++;
      end
      @(posedge clk); #1;
    end
    chk("job_completed", fin, 1'b1);
    cmd_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    #3;
    chk("cmd_ready_after", cmd_ready, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("res_valid_after", res_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[7];
  int   nb;
  int   rsv_beats;

  initial begin
`ifdef MAC_SEQ_CFG_CHECK_EN
    rsv_beats = 0;
`else
    rsv_beats = 3;
`endif
    vecs[0] = '{4'b1010, 8'd4,   100, 16'h0000, 0, 1'b1, 4};
    vecs[1] = '{4'b0001, 8'd3,   0,   16'h0029, 0, 1'b0, 3};
    vecs[2] = '{4'b1001, 8'd5,   100, 16'h0000, 5, 1'b0, 5};
    vecs[3] = '{4'b0000, 8'd0,   100, 16'h0000, 0, 1'b0, 0};
    vecs[4] = '{4'b0011, 8'd3,   100, 16'h0000, 1, 1'b0, rsv_beats};
    vecs[5] = '{4'b1000, 8'd1,   100, 16'h0000, 2, 1'b0, 1};
    vecs[6] = '{4'b0010, 8'd255, 100, 16'h0000, 0, 1'b0, 255};

    rst = 1'b0; cmd_valid = 1'b0; cmd_cfg = 4'd0; cmd_len = 8'd0;
    op_valid = 1'b0; mac_acc_in = '0; res_ready = 1'b0;
    last_cfg = 4'd0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    #3;
    chk("rst_mac_cfg", mac_cfg, 4'd0);
    chk("rst_res_data", res_data, 128'd0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_err", res_err, 1'b0);
    chk("rst_op_ready", op_ready, 1'b0);
    chk("rst_mac_en", mac_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      do_job(vecs[i].cfg, vecs[i].len, vecs[i].vprob, vecs[i].ov_pat,
             vecs[i].rdelay, vecs[i].use_pat, nb);
      chk("beat_count", nb, vecs[i].exp_beats);
    end

    // Reset in the middle of a six-beat job after two accepts.
    cmd_valid = 1'b1; cmd_cfg = 4'b0110; cmd_len = 8'd6; op_valid = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; op_valid = 1'b1;
    #3; chk("mid_accept1", mac_en, 1'b1);
    @(posedge clk); #1;
    #3; chk("mid_accept2", mac_en, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; op_valid = 1'b0;
    #3;
    chk("mid_rst_op_ready", op_ready, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_mac_cfg", mac_cfg, 4'd0);
    last_cfg = 4'd0;
    @(posedge clk); #1;
    do_job(4'b0001, 8'd1, 100, 16'h0000, 0, 1'b0, nb);
    chk("post_rst_beats", nb, 1);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      logic [3:0] rc;
      logic [7:0] rl;
      int exp_n;
      rc = 4'($urandom_range(15));
      rl = 8'($urandom_range(12));
      exp_n = int'(rl);
`ifdef MAC_SEQ_CFG_CHECK_EN
      if (rc[1:0] == 2'b11) exp_n = 0;
`endif
      do_job(rc, rl, int'($urandom_range(100, 20)), 16'h0000,
             int'($urandom_range(3)), 1'b0, nb);
      chk("rand_beats", nb, exp_n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
